// File: rtl/axi_pkg.sv
// Shared AXI-Lite definitions: response codes, initiator FSM states and fixed bus widths.
package axi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } init_state_t;

endpackage

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI-Lite initiator: one command in, one AW/W/B or AR/R exchange, one response out.
// Optional macro AXI_LITE_INITIATOR_ALIGN_CHECK_EN rejects misaligned commands with SLVERR without touching the bus.
module axi_lite_initiator
    import axi_pkg::*;
(
    input  logic              a_clk,
    input  logic              a_reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,

    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [ADDR_W-1:0] aw_addr,

    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic [STRB_W-1:0] w_strb,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_resp,

    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,

    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp
);

    init_state_t       state;
    init_state_t       state_next;

    logic              aw_done;
    logic              w_done;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              write_q;
    logic [DATA_W-1:0] rdata_q;
    resp_t             resp_q;

    logic              cmd_hs;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              ar_hs;
    logic              r_hs;
    logic              rsp_hs;
    logic              misaligned;

`ifdef AXI_LITE_INITIATOR_ALIGN_CHECK_EN
    assign misaligned = (cmd_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Every output is decoded from registered state; only cmd_ready also sees the reset.
    assign cmd_ready = (state == IDLE) && !a_reset;
    assign aw_valid  = (state == WR_REQ) && !aw_done;
    assign w_valid   = (state == WR_REQ) && !w_done;
    assign b_ready   = (state == WR_RESP);
    assign ar_valid  = (state == RD_REQ);
    assign r_ready   = (state == RD_RESP);
    assign rsp_valid = (state == RSP);

    assign aw_addr   = addr_q;
    assign ar_addr   = addr_q;
    assign w_data    = wdata_q;
    assign w_strb    = wstrb_q;
    assign rsp_write = write_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = aw_valid && aw_ready;
    assign w_hs   = w_valid && w_ready;
    assign b_hs   = b_valid && b_ready;
    assign ar_hs  = ar_valid && ar_ready;
    assign r_hs   = r_valid && r_ready;
    assign rsp_hs = rsp_valid && rsp_ready;

    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // AW and W complete independently, so each half of the write is remembered until both are in.
    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (cmd_hs) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == WR_REQ) begin
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            resp_q  <= OKAY;
        end else begin
            if (cmd_hs) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                write_q <= cmd_write;
                if (misaligned) begin
                    rdata_q <= '0;
                    resp_q  <= SLVERR;
                end
            end
            if (b_hs) begin
                rdata_q <= '0;
                resp_q  <= resp_t'(b_resp);
            end
            if (r_hs) begin
                rdata_q <= r_data;
                resp_q  <= resp_t'(r_resp);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_hs) begin
                    if (misaligned) begin
                        state_next = RSP;
                    end else if (cmd_write) begin
                        state_next = WR_REQ;
                    end else begin
                        state_next = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_next = RSP;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                if (rsp_hs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Randomized self-checking bench for axi_lite_initiator with a delay-configurable AXI-Lite target model.
`timescale 1ns/1ps
module tb_axi_lite_initiator;

    logic        a_clk = 1'b0;
    logic        a_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_resp;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    int checks = 0;
    int errors = 0;

    // target behaviour for the next transaction
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic [1:0]  r_resp_cfg = 2'b00;
    logic [31:0] r_data_cfg = 32'h0;

    // target bookkeeping
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    logic [31:0] cap_aw_addr = 32'h0, cap_w_data = 32'h0, cap_ar_addr = 32'h0;
    logic [3:0]  cap_w_strb = 4'h0;

    always #5 a_clk = ~a_clk;

    axi_lite_initiator dut (
        .a_clk     (a_clk),
        .a_reset   (a_reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .aw_addr   (aw_addr),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_strb    (w_strb),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_resp    (b_resp),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .ar_addr   (ar_addr),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_data    (r_data),
        .r_resp    (r_resp)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setTarget(input int awd, input int wd, input int bd, input int ard, input int rd,
                             input logic [1:0] bresp, input logic [1:0] rresp, input logic [31:0] rdata);
        aw_delay   = awd;
        w_delay    = wd;
        b_delay    = bd;
        ar_delay   = ard;
        r_delay    = rd;
        b_resp_cfg = bresp;
        r_resp_cfg = rresp;
        r_data_cfg = rdata;
    endtask

    task automatic pulseReset();
        @(negedge a_clk);
        a_reset   = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge a_clk);
        a_reset = 1'b0;
        @(negedge a_clk);
    endtask

    // Target: decides readies/valids on the falling edge; a ready raised while valid is high
    // always completes at the next rising edge because valids cannot drop early.
    initial begin : target
        int  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        bit  aw_got, w_got, ar_got, b_hs, r_hs;
        aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
        b_valid  = 1'b0; b_resp  = 2'b00;
        r_valid  = 1'b0; r_resp  = 2'b00; r_data = 32'h0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
        forever begin
            @(negedge a_clk);
            if (a_reset) begin
                aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
                b_valid  = 1'b0; b_resp  = 2'b00;
                r_valid  = 1'b0; r_resp  = 2'b00; r_data = 32'h0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
            end else begin
                if (aw_ready) begin aw_ready = 1'b0; n_aw++; aw_got = 1; end
                if (w_ready)  begin w_ready  = 1'b0; n_w++;  w_got  = 1; end
                if (ar_ready) begin ar_ready = 1'b0; n_ar++; ar_got = 1; end
                if (b_hs) begin b_valid = 1'b0; b_resp = 2'b00; b_hs = 0; n_b++; end
                if (r_hs) begin r_valid = 1'b0; r_resp = 2'b00; r_data = 32'h0; r_hs = 0; n_r++; end

                if (aw_valid) begin
                    if (aw_cnt >= aw_delay) begin aw_ready = 1'b1; cap_aw_addr = aw_addr; aw_cnt = 0; end
                    else aw_cnt++;
                end else aw_cnt = 0;
                if (w_valid) begin
                    if (w_cnt >= w_delay) begin
                        w_ready = 1'b1; cap_w_data = w_data; cap_w_strb = w_strb; w_cnt = 0;
                    end else w_cnt++;
                end else w_cnt = 0;
                if (ar_valid) begin
                    if (ar_cnt >= ar_delay) begin ar_ready = 1'b1; cap_ar_addr = ar_addr; ar_cnt = 0; end
                    else ar_cnt++;
                end else ar_cnt = 0;

                if (aw_got && w_got && !b_valid) begin
                    if (b_cnt >= b_delay) begin
                        b_valid = 1'b1; b_resp = b_resp_cfg; aw_got = 0; w_got = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                if (ar_got && !r_valid) begin
                    if (r_cnt >= r_delay) begin
                        r_valid = 1'b1; r_data = r_data_cfg; r_resp = r_resp_cfg; ar_got = 0; r_cnt = 0;
                    end else r_cnt++;
                end
                b_hs = b_valid && b_ready;
                r_hs = r_valid && r_ready;
            end
        end
    end

    // Protocol monitor just after each rising edge: valids and readies persist until their
    // handshake and payloads stay put while waiting.
    initial begin : monitor
        logic        pv_aw, pv_w, pv_ar, pv_rsp, pv_brdy, pv_rrdy, pv_wr;
        logic [31:0] pa_aw, pa_w, pa_ar, pa_rdata;
        logic [3:0]  pa_strb;
        logic [1:0]  pa_resp;
        pv_aw = 0; pv_w = 0; pv_ar = 0; pv_rsp = 0; pv_brdy = 0; pv_rrdy = 0; pv_wr = 0;
        pa_aw = 0; pa_w = 0; pa_ar = 0; pa_rdata = 0; pa_strb = 0; pa_resp = 0;
        forever begin
            @(posedge a_clk);
            #1;
            if (a_reset) begin
                pv_aw = 0; pv_w = 0; pv_ar = 0; pv_rsp = 0; pv_brdy = 0; pv_rrdy = 0;
            end else begin
                if (pv_aw && !aw_ready) begin
                    checkOutput("aw_valid_hold", 32'(aw_valid), 32'd1);
                    checkOutput("aw_addr_stable", aw_addr, pa_aw);
                end
                if (pv_w && !w_ready) begin
                    checkOutput("w_valid_hold", 32'(w_valid), 32'd1);
                    checkOutput("w_data_stable", w_data, pa_w);
                    checkOutput("w_strb_stable", 32'(w_strb), 32'(pa_strb));
                end
                if (pv_ar && !ar_ready) begin
                    checkOutput("ar_valid_hold", 32'(ar_valid), 32'd1);
                    checkOutput("ar_addr_stable", ar_addr, pa_ar);
                end
                if (pv_brdy && !b_valid) checkOutput("b_ready_hold", 32'(b_ready), 32'd1);
                if (pv_rrdy && !r_valid) checkOutput("r_ready_hold", 32'(r_ready), 32'd1);
                if (b_ready) checkOutput("b_ready_before_aw_w", 32'(aw_valid | w_valid), 32'd0);
                checkOutput("rd_wr_overlap", 32'((aw_valid | w_valid | b_ready) & (ar_valid | r_ready)), 32'd0);
                if (pv_rsp && !rsp_ready) begin
                    checkOutput("rsp_valid_hold", 32'(rsp_valid), 32'd1);
                    checkOutput("rsp_rdata_stable", rsp_rdata, pa_rdata);
                    checkOutput("rsp_resp_stable", 32'(rsp_resp), 32'(pa_resp));
                    checkOutput("rsp_write_stable", 32'(rsp_write), 32'(pv_wr));
                end
                pv_aw = aw_valid; pv_w = w_valid; pv_ar = ar_valid; pv_rsp = rsp_valid;
                pv_brdy = b_ready; pv_rrdy = r_ready; pv_wr = rsp_write;
                pa_aw = aw_addr; pa_w = w_data; pa_strb = w_strb; pa_ar = ar_addr;
                pa_rdata = rsp_rdata; pa_resp = rsp_resp;
            end
        end
    end

    // One command end to end, checked against a transaction-level expectation.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input int hold);
        bit          skip_bus;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat, lat, k;
        int          base_aw, base_w, base_b, base_ar, base_r;
`ifdef AXI_LITE_INITIATOR_ALIGN_CHECK_EN
        skip_bus = (addr[1:0] != 2'b00);
`else
        skip_bus = 1'b0;
`endif
        if (skip_bus) begin
            exp_resp = 2'b10; exp_rdata = 32'h0; exp_lat = 1;
        end else if (wr) begin
            exp_resp = b_resp_cfg; exp_rdata = 32'h0;
            exp_lat = ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay + 3;
        end else begin
            exp_resp = r_resp_cfg; exp_rdata = r_data_cfg;
            exp_lat = ar_delay + r_delay + 3;
        end
        base_aw = n_aw; base_w = n_w; base_b = n_b; base_ar = n_ar; base_r = n_r;

        @(negedge a_clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge a_clk);
            k++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_accept_timeout", 32'd0, 32'd1);
            pulseReset();
            return;
        end
        @(negedge a_clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge a_clk);
            lat++;
        end
        if (!rsp_valid) begin
            checkOutput("rsp_timeout", 32'd0, 32'd1);
            pulseReset();
            return;
        end
        checkOutput("rsp_latency", 32'(lat), 32'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            checkOutput("cmd_ready_in_rsp", 32'(cmd_ready), 32'd0);
            cmd_valid = 1'b1;
            cmd_write = ~wr;
            cmd_addr  = 32'h0000_0100;
            @(negedge a_clk);
        end
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_write", 32'(rsp_write), 32'(wr));
        checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
        checkOutput("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(negedge a_clk);
        rsp_ready = 1'b0;
        checkOutput("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
        checkOutput("rsp_valid_after_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("aw_count", 32'(n_aw - base_aw), 32'(wr && !skip_bus));
        checkOutput("w_count", 32'(n_w - base_w), 32'(wr && !skip_bus));
        checkOutput("b_count", 32'(n_b - base_b), 32'(wr && !skip_bus));
        checkOutput("ar_count", 32'(n_ar - base_ar), 32'(!wr && !skip_bus));
        checkOutput("r_count", 32'(n_r - base_r), 32'(!wr && !skip_bus));
        if (!skip_bus && wr) begin
            checkOutput("aw_addr", cap_aw_addr, addr);
            checkOutput("w_data", cap_w_data, wdata);
            checkOutput("w_strb", 32'(cap_w_strb), 32'(strb));
        end
        if (!skip_bus && !wr) checkOutput("ar_addr", cap_ar_addr, addr);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        a_reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
        repeat (2) @(negedge a_clk);
        checkOutput("reset_valids_readies",
                    32'({cmd_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid}), 32'd0);
        checkOutput("reset_aw_addr", aw_addr, 32'h0);
        checkOutput("reset_w_data", w_data, 32'h0);
        checkOutput("reset_w_strb", 32'(w_strb), 32'd0);
        checkOutput("reset_ar_addr", ar_addr, 32'h0);
        checkOutput("reset_rsp_payload", 32'({rsp_write, rsp_resp}), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        a_reset = 1'b0;
        @(negedge a_clk);
        checkOutput("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

        $display("[TB] zero-wait write");
        setTarget(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);

        $display("[TB] read with delayed R");
        setTarget(0, 0, 0, 0, 3, 2'b00, 2'b00, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0);

        $display("[TB] write with W accepted before AW");
        setTarget(2, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        applyStimulus(1'b1, 32'h0000_0024, 32'h1234_5678, 4'h5, 0);

        $display("[TB] read DECERR with rsp_ready held low");
        setTarget(0, 0, 0, 0, 0, 2'b00, 2'b11, 32'hCAFE_F00D);
        applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'h0, 5);

        $display("[TB] misaligned read");
        setTarget(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0BAD_F00D);
        applyStimulus(1'b0, 32'h0000_0003, 32'h0, 4'h0, 0);

        $display("[TB] reset during WR_REQ");
        setTarget(20, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        @(negedge a_clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0080;
        cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
        checkOutput("rst_test_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge a_clk);
        cmd_valid = 1'b0;
        checkOutput("rst_test_aw_valid", 32'(aw_valid), 32'd1);
        a_reset = 1'b1;
        @(negedge a_clk);
        checkOutput("rst_test_all_idle",
                    32'({cmd_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid}), 32'd0);
        @(negedge a_clk);
        a_reset = 1'b0;
        @(negedge a_clk);
        checkOutput("rst_test_cmd_ready_after", 32'(cmd_ready), 32'd1);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            logic [31:0] addr;
            addr = $urandom();
            if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
            setTarget(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom());
            applyStimulus(1'($urandom_range(0, 1)), addr, $urandom(), 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 2)));
        end

        repeat (2) @(negedge a_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
